// File: rtl/segre_mmu_arbiter.sv
// L1 line-refill arbiter: round-robin icache/dcache misses onto one memory read port; miss-to-fill >= 3 cycles.
// Memory backpressure holds MEM_REQ indefinitely; a repeat miss while its side is pending is dropped as a duplicate.
module segre_mmu_arbiter #(
    parameter int ADDR_SIZE     = 32,
    parameter int LANE_SIZE     = 128,
    parameter int IC_INDEX_SIZE = 2,
    parameter int DC_INDEX_SIZE = 2
) (
    input  logic                     clk_i,
    input  logic                     rsn_i,
    input  logic                     ic_miss_i,
    input  logic [ADDR_SIZE-1:0]     ic_addr_i,
    input  logic                     dc_miss_i,
    input  logic [ADDR_SIZE-1:0]     dc_addr_i,
    output logic                     mem_rd_o,
    output logic [ADDR_SIZE-1:0]     mem_addr_o,
    input  logic                     mem_ready_i,
    input  logic [LANE_SIZE-1:0]     mem_data_i,
    output logic                     ic_mmu_data_o,
    output logic [LANE_SIZE-1:0]     ic_wr_data_o,
    output logic [IC_INDEX_SIZE-1:0] ic_lru_index_o,
    output logic                     dc_mmu_data_o,
    output logic [LANE_SIZE-1:0]     dc_wr_data_o,
    output logic [DC_INDEX_SIZE-1:0] dc_lru_index_o,
    output logic                     busy_o
);

    localparam int OFF_BITS = $clog2(LANE_SIZE / 8);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {ADDR_SIZE{1'b1}} << OFF_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        FILL    = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ic_pend;
    logic                     r_dc_pend;
    logic [ADDR_SIZE-1:0]     r_ic_addr;
    logic [ADDR_SIZE-1:0]     r_dc_addr;
    logic                     r_prio;
    logic                     r_gnt;      // 0 = icache, 1 = dcache
    logic [LANE_SIZE-1:0]     r_line;
    logic [IC_INDEX_SIZE-1:0] r_ic_ptr;
    logic [DC_INDEX_SIZE-1:0] r_dc_ptr;
    logic                     w_any_pend;
    logic                     w_gnt_nxt;
    logic [ADDR_SIZE-1:0]     w_gnt_addr;

    assign w_any_pend = r_ic_pend | r_dc_pend;
    assign w_gnt_nxt  = (r_ic_pend & r_dc_pend) ? r_prio : r_dc_pend;
    assign w_gnt_addr = r_gnt ? r_dc_addr : r_ic_addr;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_pend) w_state_nxt = MEM_REQ;
            MEM_REQ: if (mem_ready_i) w_state_nxt = FILL;
            FILL:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_ic_pend <= 1'b0;
            r_dc_pend <= 1'b0;
            r_ic_addr <= '0;
            r_dc_addr <= '0;
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_line    <= '0;
            r_ic_ptr  <= '0;
            r_dc_ptr  <= '0;
        end else begin
            if (ic_miss_i && !r_ic_pend) begin
                r_ic_pend <= 1'b1;
                r_ic_addr <= ic_addr_i;
            end
            if (dc_miss_i && !r_dc_pend) begin
                r_dc_pend <= 1'b1;
                r_dc_addr <= dc_addr_i;
            end
            if (r_state == IDLE && w_any_pend) begin
                r_gnt <= w_gnt_nxt;
            end
            if (r_state == MEM_REQ && mem_ready_i) begin
                r_line <= mem_data_i;
            end
            // The served side's flag is still set here, so its own new miss above was already ignored.
            if (r_state == FILL) begin
                r_prio <= ~r_gnt;
                if (r_gnt) begin
                    r_dc_pend <= 1'b0;
                    r_dc_ptr  <= r_dc_ptr + DC_INDEX_SIZE'(1);
                end else begin
                    r_ic_pend <= 1'b0;
                    r_ic_ptr  <= r_ic_ptr + IC_INDEX_SIZE'(1);
                end
            end
        end
    end

    assign mem_rd_o       = (r_state == MEM_REQ);
    assign mem_addr_o     = (r_state == MEM_REQ) ? (w_gnt_addr & ALIGN_MASK) : '0;
    assign ic_mmu_data_o  = (r_state == FILL) & ~r_gnt;
    assign dc_mmu_data_o  = (r_state == FILL) & r_gnt;
    assign ic_wr_data_o   = r_line;
    assign dc_wr_data_o   = r_line;
    assign ic_lru_index_o = r_ic_ptr;
    assign dc_lru_index_o = r_dc_ptr;
    assign busy_o         = (r_state != IDLE) | w_any_pend;

endmodule

// File: tb/tb_segre_mmu_arbiter.sv
// Bench for segre_mmu_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model (who is being served, has the line arrived yet).
module tb_segre_mmu_arbiter;

    localparam int LINES = 4;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         ic_miss_i = 1'b0;
    logic [31:0]  ic_addr_i = '0;
    logic         dc_miss_i = 1'b0;
    logic [31:0]  dc_addr_i = '0;
    logic         mem_rd_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i = 1'b0;
    logic [127:0] mem_data_i = '0;
    logic         ic_mmu_data_o;
    logic [127:0] ic_wr_data_o;
    logic [1:0]   ic_lru_index_o;
    logic         dc_mmu_data_o;
    logic [127:0] dc_wr_data_o;
    logic [1:0]   dc_lru_index_o;
    logic         busy_o;

    segre_mmu_arbiter #(
        .ADDR_SIZE(32), .LANE_SIZE(128), .IC_INDEX_SIZE(2), .DC_INDEX_SIZE(2)
    ) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
        .ic_mmu_data_o(ic_mmu_data_o), .ic_wr_data_o(ic_wr_data_o), .ic_lru_index_o(ic_lru_index_o),
        .dc_mmu_data_o(dc_mmu_data_o), .dc_wr_data_o(dc_wr_data_o), .dc_lru_index_o(dc_lru_index_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending misses per side (0 = icache, 1 = dcache), the side under
    // service (-1 when none) and whether memory has already handed over its line.
    bit           m_pend [2];
    logic [31:0]  m_addr [2];
    int           m_ptr  [2];
    int           m_prio;
    int           m_side;
    bit           m_have;
    logic [127:0] m_line;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pend[s] = 1'b0;
            m_addr[s] = '0;
            m_ptr[s]  = 0;
        end
        m_prio = 0;
        m_side = -1;
        m_have = 1'b0;
        m_line = '0;
    endtask

    task automatic check_model();
        bit          e_rd;
        logic [31:0] e_addr;
        e_rd   = (m_side >= 0) && !m_have;
        e_addr = '0;
        if (e_rd) e_addr = (m_addr[m_side] / 16) * 16;
        chk("mem_rd", 128'(mem_rd_o), 128'(e_rd));
        chk("mem_addr", 128'(mem_addr_o), 128'(e_addr));
        chk("ic_strobe", 128'(ic_mmu_data_o), 128'((m_side == 0) && m_have));
        chk("dc_strobe", 128'(dc_mmu_data_o), 128'((m_side == 1) && m_have));
        chk("ic_wr_data", ic_wr_data_o, m_line);
        chk("dc_wr_data", dc_wr_data_o, m_line);
        chk("ic_lru", 128'(ic_lru_index_o), 128'(m_ptr[0]));
        chk("dc_lru", 128'(dc_lru_index_o), 128'(m_ptr[1]));
        chk("busy", 128'(busy_o), 128'((m_side >= 0) || m_pend[0] || m_pend[1]));
    endtask

    // Effect of one rising edge with the currently driven inputs.
    task automatic model_edge();
        bit old0, old1;
        old0 = m_pend[0];
        old1 = m_pend[1];
        if (ic_miss_i && !old0) begin m_pend[0] = 1'b1; m_addr[0] = ic_addr_i; end
        if (dc_miss_i && !old1) begin m_pend[1] = 1'b1; m_addr[1] = dc_addr_i; end
        if (m_side >= 0 && m_have) begin
            m_pend[m_side] = 1'b0;
            m_ptr[m_side]  = (m_ptr[m_side] + 1) % LINES;
            m_prio = 1 - m_side;
            m_side = -1;
            m_have = 1'b0;
        end else if (m_side >= 0) begin
            if (mem_ready_i) begin
                m_line = mem_data_i;
                m_have = 1'b1;
            end
        end else if (old0 || old1) begin
            m_side = (old0 && old1) ? m_prio : (old1 ? 1 : 0);
        end
    endtask

    task automatic step(input logic icm, input logic [31:0] ica, input logic dcm,
                        input logic [31:0] dca, input logic rdy);
        @(negedge clk_i);
        check_model();
        ic_miss_i   = icm;
        ic_addr_i   = ica;
        dc_miss_i   = dcm;
        dc_addr_i   = dca;
        mem_ready_i = rdy;
        mem_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_edge();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rsn_i       = 1'b0;
        ic_miss_i   = 1'b0;
        dc_miss_i   = 1'b0;
        mem_ready_i = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_rd", 128'(mem_rd_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        check_model();
        @(negedge clk_i);
        rsn_i = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #1;
        chk("por_mem_addr", 128'(mem_addr_o), 128'(0));
        chk("por_strobes", 128'({ic_mmu_data_o, dc_mmu_data_o}), 128'(0));
        check_model();
        apply_reset();

        // Single icache miss, memory ready on first request cycle.
        step(1, 32'h0000_1234, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s1_pend_busy", 128'(busy_o), 128'(1));
        chk("s1_no_rd_yet", 128'(mem_rd_o), 128'(0));
        step(0, 0, 0, 0, 1);
        chk("s1_rd", 128'(mem_rd_o), 128'(1));
        chk("s1_addr", 128'(mem_addr_o), 128'(32'h0000_1230));
        step(0, 0, 0, 0, 0);
        chk("s1_strobe", 128'(ic_mmu_data_o), 128'(1));
        chk("s1_victim", 128'(ic_lru_index_o), 128'(0));
        chk("s1_dc_quiet", 128'(dc_mmu_data_o), 128'(0));
        step(0, 0, 0, 0, 0);
        chk("s1_strobe_off", 128'(ic_mmu_data_o), 128'(0));
        chk("s1_ptr_next", 128'(ic_lru_index_o), 128'(1));

        // Simultaneous pair: icache first, then dcache, then icache first again.
        apply_reset();
        step(1, 32'h100, 1, 32'h2008, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pair_first_addr", 128'(mem_addr_o), 128'(32'h100));
        step(0, 0, 0, 0, 0);
        chk("pair_first_ic", 128'(ic_mmu_data_o), 128'(1));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pair_second_addr", 128'(mem_addr_o), 128'(32'h2000));
        step(0, 0, 0, 0, 0);
        chk("pair_second_dc", 128'(dc_mmu_data_o), 128'(1));
        step(1, 32'h300, 1, 32'h4000, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pair2_ic_first", 128'(mem_addr_o), 128'(32'h300));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

        // Five dcache misses walk the dcache replacement pointer.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 32'h5000 + 32'(k * 64), 0);
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
                step(0, 0, 0, 0, 1);
                if (dc_mmu_data_o) begin
                    found = 1'b1;
                    chk("dc_victim_seq", 128'(dc_lru_index_o), 128'(k % 4));
                    chk("ic_ptr_idle", 128'(ic_lru_index_o), 128'(0));
                end
            end
            if (!found) chk("dc_fill_timeout", 128'(0), 128'(1));
        end

        // Memory stalls 10 cycles; duplicate icache misses must not disturb the request.
        apply_reset();
        step(1, 32'h0000_4004, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step((i % 3) == 0, 32'h0000_9990, 0, 0, 0);
            chk("stall_rd", 128'(mem_rd_o), 128'(1));
            chk("stall_addr", 128'(mem_addr_o), 128'(32'h0000_4000));
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("stall_fill", 128'(ic_mmu_data_o), 128'(1));
        step(0, 0, 0, 0, 0);

        // Reset while a dcache read is outstanding.
        apply_reset();
        step(0, 0, 1, 32'h3000, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("abort_pre_rd", 128'(mem_rd_o), 128'(1));
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            chk("abort_no_strobe", 128'({ic_mmu_data_o, dc_mmu_data_o}), 128'(0));
            chk("abort_idle", 128'(busy_o), 128'(0));
        end

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 399) == 0) apply_reset();
            step($urandom_range(0, 3) == 0, $urandom(), $urandom_range(0, 3) == 0, $urandom(),
                 $urandom_range(0, 2) == 0);
            if (ic_mmu_data_o && dc_mmu_data_o) chk("both_strobes", 128'(1), 128'(0));
        end
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/segre_mmu_arbiter.md
# segre_mmu_arbiter

Line-refill controller between the L1 caches and the single main-memory read port. It latches instruction-cache and data-cache miss requests and arbitrates them round-robin. It runs one line read at a time on the memory handshake and returns the line to the requesting cache as a one-cycle fill pulse, together with the victim line index from a per-cache round-robin replacement pointer. It sits beside the core FSM and drives the `mmu_data_i` / `mmu_wr_data_i` / `mmu_lru_index_i` inputs of the IF and MEM stages.

## Interface
- `ADDR_SIZE`, 32, byte address width
- `LANE_SIZE`, 128, cache line width in bits (multiple of 8, power of 2)
- `IC_INDEX_SIZE`, 2, icache line-index width (2**IC_INDEX_SIZE lines)
- `DC_INDEX_SIZE`, 2, dcache line-index width
- `clk_i`  in  1  clock, all state on rising edge
- `rsn_i`  in  1  asynchronous, active-low reset
- `ic_miss_i`  in  1  icache miss request, sampled each edge
- `ic_addr_i`  in  ADDR_SIZE  icache miss byte address, valid with `ic_miss_i`
- `dc_miss_i`  in  1  dcache miss request
- `dc_addr_i`  in  ADDR_SIZE  dcache miss byte address, valid with `dc_miss_i`
- `mem_rd_o`  out  1  memory line-read request, held until accepted
- `mem_addr_o`  out  ADDR_SIZE  line-aligned read address
- `mem_ready_i`  in  1  memory returns line, `mem_data_i` valid this cycle
- `mem_data_i`  in  LANE_SIZE  returned line
- `ic_mmu_data_o`  out  1  one-cycle icache fill strobe
- `ic_wr_data_o`  out  LANE_SIZE  fill line for icache
- `ic_lru_index_o`  out  IC_INDEX_SIZE  icache victim index
- `dc_mmu_data_o`, `dc_wr_data_o`, `dc_lru_index_o`  out  1/LANE_SIZE/DC_INDEX_SIZE  same for dcache
- `busy_o`  out  1  FSM not in IDLE or any request pending

## Operation
- Pending flags `ic_pend` and `dc_pend`, each with an address register. A miss sets its flag and captures its address only if that flag is clear. A miss while the same flag is set is ignored; the caches stall on a miss, so this is a duplicate.
- Line alignment: `mem_addr_o` = granted address with the low log2(LANE_SIZE/8) bits forced to 0.
- Priority bit `prio`: 0 = icache first, reset to 0. Both pending in IDLE: grant the side `prio` selects. One pending: grant it. After every fill, `prio` points to the side not just served.
- FSM states:
  - IDLE: any pend set -> MEM_REQ, latch grant.
  - MEM_REQ: `mem_rd_o`=1, `mem_addr_o` stable. `mem_ready_i`=1 -> latch `mem_data_i`, -> FILL. Otherwise stay.
  - FILL: the granted side's `*_mmu_data_o`=1 and `*_wr_data_o` = latched line. At the closing edge: clear the granted pend flag, increment that side's replacement pointer (wraps 2**N-1 -> 0), update `prio`, -> IDLE.
- `*_lru_index_o` always shows the current pointer value. The value during FILL is the victim.
- `*_wr_data_o` shows the latched line at all times. It is only meaningful during FILL.
- A miss from the side being filled, arriving in the FILL cycle, is discarded, since the flag is still set. A miss from the other side in any state is accepted.
- `mem_ready_i` outside MEM_REQ is ignored.

## Timing
- Reset (asynchronous assert, immediate effect): state IDLE; pend flags, `prio`, and both pointers = 0; line register = 0. All outputs 0: `mem_rd_o`, `mem_addr_o`, both strobes, both wr_data, both lru_index, `busy_o`.
- Reset mid-transaction: the request is dropped and `mem_rd_o` falls without waiting for `mem_ready_i`. Memory must tolerate an abandoned read.
- Latency, miss sampled at edge E0:
  - pend visible in cycle 1
  - `mem_rd_o`=1 from cycle 2
  - `mem_ready_i` in cycle k (k≥2) -> fill strobe in cycle k+1
  - minimum miss-to-strobe is 3 cycles
- Exactly one strobe per served miss, never both strobes in the same cycle.
- Back-to-back service: the second request's `mem_rd_o` rises 2 cycles after the first FILL cycle, via one IDLE cycle.
- `busy_o` is combinational from the state and pend flags.

## Test plan
- Single icache miss, addr 0x0000_1234, `mem_ready_i` in the first MEM_REQ cycle:
  - `mem_addr_o`=0x0000_1230
  - `ic_mmu_data_o` is 1 for exactly one cycle, 3 cycles after the miss
  - `ic_lru_index_o`=0 during the strobe, then 1
  - `dc_mmu_data_o` stays 0
- Simultaneous `ic_miss_i` (0x100) and `dc_miss_i` (0x2008) after reset: the icache is served first, then the dcache read uses `mem_addr_o`=0x2000. The next simultaneous pair is also served icache first, because `prio` flipped to icache after the dcache service.
- Five consecutive dcache misses with `IC_INDEX_SIZE`/`DC_INDEX_SIZE`=2: `dc_lru_index_o` during strobes is 0, 1, 2, 3, 0, and `ic_lru_index_o` stays 0.
- Memory holds `mem_ready_i`=0 for 10 cycles: `mem_rd_o` and `mem_addr_o` are held constant for all 10 cycles. A repeated `ic_miss_i` with a different address during this time does not change `mem_addr_o`.
- `rsn_i` pulsed low while in MEM_REQ: `mem_rd_o` is 0 in the same cycle. After release, no strobe occurs and `busy_o`=0.
- `dc_miss_i` arriving during an icache FILL cycle: accepted, and its `mem_rd_o` rises 2 cycles later.
